// File: rtl/add_stream_pkg.sv
// add_stream_pkg: shared types and constants for the add_stream custom-RTL tasks.
//   state_e   - task control FSM encoding
//   eot_bit() - position of the end-of-transfer flag in a stream word
//   EOT_FLAG  - value of the flag on the closing token (payload is all zeros)
package add_stream_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    CLOSE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Stream words carry the eot flag just above the payload.
  function automatic int eot_bit(input int data_width);
    return data_width;
  endfunction

  localparam logic EOT_FLAG = 1'b1;

endpackage

// File: rtl/stream_out_reg.sv
// stream_out_reg: one-entry registered output buffer in front of a FIFO write port.
//   clk_i, rst_ni    clock, synchronous active-low reset
//   load_i           capture load_data_i this cycle (caller must respect can_load_o)
//   load_data_i      word to capture
//   c_full_n_i       downstream FIFO has space
//   valid_o          buffer holds a word
//   can_load_o       buffer is empty or is being drained this cycle
//   c_din_o          registered word toward the FIFO
//   c_write_o        push strobe toward the FIFO
module stream_out_reg #(
  parameter int W = 33
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  input  logic         c_full_n_i,
  output logic         valid_o,
  output logic         can_load_o,
  output logic [W-1:0] c_din_o,
  output logic         c_write_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // A load overrides the drain, so load+drain in one cycle keeps valid set.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && c_full_n_i) valid_d = 1'b0;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // c_din comes straight from a flop: no path from c_full_n to data.
  assign valid_o    = valid_q;
  assign can_load_o = ~valid_q | c_full_n_i;
  assign c_din_o    = data_q;
  assign c_write_o  = valid_q & c_full_n_i;

endmodule

// File: rtl/add_stream_core.sv
// add_stream_core: ap_ctrl_hs task adding two streams element-wise into a third.
//   ap_clk, ap_rst_n              clock, synchronous active-low reset
//   ap_start/ap_ready/ap_done     handshake with the parent task FSM
//   ap_idle                       high in IDLE
//   n                             element count, sampled on start
//   a_s_*, b_s_*                  input FIFO read ports (word = {eot, data})
//   c_din, c_full_n, c_write      output FIFO write port
// Writes n sums followed by one eot token, then pulses ap_done/ap_ready.
module add_stream_core
  import add_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_ready,
  output logic                  ap_done,
  output logic                  ap_idle,
  input  logic [63:0]           n,
  input  logic [DATA_WIDTH:0]   a_s_dout,
  input  logic                  a_s_empty_n,
  output logic                  a_s_read,
  input  logic [DATA_WIDTH:0]   b_s_dout,
  input  logic                  b_s_empty_n,
  output logic                  b_s_read,
  output logic [DATA_WIDTH:0]   c_din,
  input  logic                  c_full_n,
  output logic                  c_write
);

  localparam int EB = eot_bit(DATA_WIDTH);
  localparam logic [EB:0] EOT_TOKEN = {EOT_FLAG, {DATA_WIDTH{1'b0}}};

  state_e                state_q, state_d;
  logic [63:0]           rem_q, rem_d;
  logic                  fire, load_eot, load, can_load, out_valid;
  logic [DATA_WIDTH-1:0] sum;
  logic [EB:0]           load_data;
  logic                  unused_eot;

  // Input eot flags carry no meaning here; the count alone bounds the transfer.
  assign unused_eot = a_s_dout[EB] ^ b_s_dout[EB];

  assign sum = a_s_dout[DATA_WIDTH-1:0] + b_s_dout[DATA_WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    fire     = 1'b0;
    load_eot = 1'b0;
    case (state_q)
      IDLE: begin
        if (ap_start) begin
          rem_d   = n;
          state_d = (n == 64'd0) ? CLOSE : RUN;
        end
      end
      RUN: begin
        // Both streams are popped together or not at all.
        fire = a_s_empty_n & b_s_empty_n & can_load & (rem_q != 64'd0);
        if (fire) rem_d = rem_q - 64'd1;
        if (rem_d == 64'd0) state_d = CLOSE;
      end
      CLOSE: begin
        if (can_load) begin
          load_eot = 1'b1;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (!out_valid) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      rem_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  assign load      = fire | load_eot;
  assign load_data = fire ? {1'b0, sum} : EOT_TOKEN;

  stream_out_reg #(.W(EB + 1)) u_out (
    .clk_i       (ap_clk),
    .rst_ni      (ap_rst_n),
    .load_i      (load),
    .load_data_i (load_data),
    .c_full_n_i  (c_full_n),
    .valid_o     (out_valid),
    .can_load_o  (can_load),
    .c_din_o     (c_din),
    .c_write_o   (c_write)
  );

  assign a_s_read = fire;
  assign b_s_read = fire;
  assign ap_idle  = (state_q == IDLE);
  assign ap_done  = (state_q == DONE);
  assign ap_ready = (state_q == DONE);

endmodule

// File: tb/tb_add_stream_core.sv
module tb_add_stream_core;
  localparam int DW = 32;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          ap_start = 1'b0;
  logic          ap_ready, ap_done, ap_idle;
  logic [63:0]   n = '0;
  logic [DW:0]   a_s_dout = '0, b_s_dout = '0;
  logic          a_s_empty_n = 1'b0, b_s_empty_n = 1'b0;
  logic          a_s_read, b_s_read;
  logic [DW:0]   c_din;
  logic          c_full_n = 1'b1;
  logic          c_write;

  add_stream_core #(.DATA_WIDTH(DW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_idle(ap_idle), .n(n),
    .a_s_dout(a_s_dout), .a_s_empty_n(a_s_empty_n), .a_s_read(a_s_read),
    .b_s_dout(b_s_dout), .b_s_empty_n(b_s_empty_n), .b_s_read(b_s_read),
    .c_din(c_din), .c_full_n(c_full_n), .c_write(c_write)
  );

  always #5 ap_clk = ~ap_clk;

  int          total = 0, bad = 0, cyc = 0, pops = 0, dwr = 0, ewr = 0, dones = 0;
  int          first_wr = 0, last_wr = 0;
  logic [DW:0] a_q[$], b_q[$], exp_q[$];
  bit          rnd = 0, freeze = 0, start_g = 0;
  logic [63:0] n_g = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Queue one element pair plus its expected sum.
  task automatic push(input logic [DW:0] a, input logic [DW:0] b);
    logic [DW-1:0] s;
    s = a[DW-1:0] + b[DW-1:0];
    a_q.push_back(a);
    b_q.push_back(b);
    exp_q.push_back({1'b0, s});
  endtask

  // One clock: drive at negedge, sample 1ns later (state stable until posedge).
  task automatic step();
    logic [DW:0] e;
    @(negedge ap_clk);
    cyc++;
    ap_start    = start_g;
    n           = n_g;
    a_s_empty_n = !freeze && a_q.size() != 0 && (!rnd || $urandom_range(0, 2) != 0);
    b_s_empty_n = !freeze && b_q.size() != 0 && (!rnd || $urandom_range(0, 2) != 0);
    a_s_dout    = (a_q.size() != 0) ? a_q[0] : '0;
    b_s_dout    = (b_q.size() != 0) ? b_q[0] : '0;
    c_full_n    = !rnd || $urandom_range(0, 2) != 0;
    #1;
    if (ap_rst_n) begin
      if (a_s_read || b_s_read) begin
        chk("pair_pop", 64'({a_s_read, b_s_read}), 64'd3);
        chk("pop_nonempty", 64'({a_s_empty_n, b_s_empty_n}), 64'd3);
        if (a_s_read && a_q.size() != 0) void'(a_q.pop_front());
        if (b_s_read && b_q.size() != 0) void'(b_q.pop_front());
        pops++;
      end
      if (c_write) begin
        if (exp_q.size() == 0) chk("extra_write", 64'(exp_q.size()), 64'd1);
        else begin
          e = exp_q.pop_front();
          chk("c_din", 64'(c_din), 64'(e));
          if (c_din[DW]) ewr++;
          else begin
            if (dwr == 0) first_wr = cyc;
            last_wr = cyc;
            dwr++;
          end
        end
      end
      if (ap_done || ap_ready) begin
        chk("done_eq_ready", 64'(ap_ready), 64'(ap_done));
        if (ap_done) dones++;
      end
    end
  endtask

  // One invocation; elements must already be pushed. dcyc = cycles from the
  // cycle ending in the start edge to the cycle showing ap_done.
  task automatic run(input logic [63:0] nn, input bit hold, output int dcyc);
    int s, d0;
    dwr = 0; ewr = 0; d0 = dones;
    exp_q.push_back({1'b1, {DW{1'b0}}});
    n_g = nn; start_g = 1; s = cyc + 1; dcyc = -1;
    for (int k = 0; k < 300 && dcyc < 0; k++) begin
      step();
      if (ap_done) begin
        dcyc = cyc - s;
        if (!hold) start_g = 0;
      end
    end
    if (dcyc < 0) chk("timeout", 64'(dones - d0), 64'd1);
    chk("data_tokens", 64'(dwr), nn);
    chk("eot_tokens", 64'(ewr), 64'd1);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    chk("one_done", 64'(dones - d0), 64'd1);
    step();
    chk("idle_after", 64'(ap_idle), 64'd1);
    chk("done_pulse", 64'(ap_done), 64'd0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_idle", 64'(ap_idle), 64'd1);
    chk("rst_done", 64'({ap_done, ap_ready}), 64'd0);
    chk("rst_reads", 64'({a_s_read, b_s_read}), 64'd0);
    chk("rst_cwrite", 64'(c_write), 64'd0);
    chk("rst_cdin", 64'(c_din), 64'd0);
  endtask

  initial begin
    int d;
    // Power-on reset
    freeze = 1;
    step(); step();
    ap_rst_n = 1;
    step();
    chk_reset_vals();
    freeze = 0;

    // Basic n=4, full throughput
    push(33'd1, 33'd10); push(33'd2, 33'd20); push(33'd3, 33'd30); push(33'd4, 33'd40);
    run(64'd4, 0, d);
    chk("consecutive", 64'(last_wr - first_wr), 64'd3);

    // n=0: only eot; done right after the third edge following the start edge
    run(64'd0, 0, d);
    chk("n0_latency", 64'(d), 64'd4);

    // Wrap-around
    push({1'b0, 32'hFFFF_FFFF}, 33'd2);
    run(64'd1, 0, d);

    // Random empty_n / full_n, random input eot bits (ignored)
    rnd = 1;
    for (int i = 0; i < 3; i++)
      push({1'($urandom_range(0, 1)), 32'($urandom)}, {1'($urandom_range(0, 1)), 32'($urandom)});
    run(64'd3, 0, d);
    rnd = 0;

    // Reset mid-operation after 2 of 5 pops
    for (int i = 0; i < 5; i++) push(33'(i + 100), 33'(i * 7));
    pops = 0; d = dones; n_g = 64'd5; start_g = 1;
    for (int k = 0; k < 50 && pops < 2; k++) step();
    chk("pops_before_rst", 64'(pops), 64'd2);
    start_g = 0; ap_rst_n = 0; freeze = 1;
    step();
    ap_rst_n = 1;
    step();
    chk_reset_vals();
    chk("no_done_on_rst", 64'(dones - d), 64'd0);
    a_q.delete(); b_q.delete(); exp_q.delete();
    freeze = 0;
    push(33'd5, 33'd6); push(33'd7, 33'd8);
    run(64'd2, 0, d);

    // ap_start held across DONE: one IDLE cycle, then a second invocation
    push(33'd9, 33'd1);
    run(64'd1, 1, d);
    push(33'd11, 33'd12);
    run(64'd1, 0, d);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add_stream_core.md
# add_stream_core

Custom-RTL child task that performs element-wise addition of two input streams into one output stream. It is instantiated under an upper-level task FSM, which drives its ap_start, supplies the scalar element count, and waits for its ap_ready/ap_done. Follows ap_ctrl_hs semantics on the control side and FIFO read/write semantics on the stream side. Sustains one element per cycle.

## Interface
Parameters:
- DATA_WIDTH, 32, payload width per element. Stream words are DATA_WIDTH+1 bits; the MSB is the end-of-transfer (eot) flag.

Ports:
- ap_clk  in  1  clock; all logic is on the rising edge
- ap_rst_n  in  1  reset; synchronous, active-low
- ap_start  in  1  start request; the parent holds it high until ap_ready
- ap_ready  out  1  one-cycle pulse; task accepted and completed
- ap_done  out  1  one-cycle pulse, coincident with ap_ready
- ap_idle  out  1  high while the block is in IDLE
- n  in  64  element count; sampled on start
- a_s_dout  in  DATA_WIDTH+1  input stream A word
- a_s_empty_n  in  1  A has data
- a_s_read  out  1  pop A
- b_s_dout, b_s_empty_n, b_s_read: same as A, for stream B
- c_din  out  DATA_WIDTH+1  output stream word
- c_full_n  in  1  C has space
- c_write  out  1  push C

## Operation
- States (shared package enum): IDLE, RUN, CLOSE, DRAIN, DONE.
- IDLE: ap_idle=1. When ap_start=1: latch n into remaining[63:0], then go to RUN, or to CLOSE if n==0.
- RUN: fire = a_s_empty_n & b_s_empty_n & (~out_valid | c_full_n) & (remaining!=0).
  - On fire: assert a_s_read and b_s_read in the same cycle.
  - Load the output register with {1'b0, a[DATA_WIDTH-1:0] + b[DATA_WIDTH-1:0]}. The sum wraps mod 2^DATA_WIDTH. The input eot bits are ignored.
  - Decrement remaining.
  - When remaining reaches 0 (including the firing cycle), go to CLOSE.
- CLOSE: when the output register is free or draining this cycle (~out_valid | c_full_n), load the eot token {1'b1, 0} and go to DRAIN.
- DRAIN: wait until out_valid==0, then go to DONE.
- DONE: assert ap_done=ap_ready=1 for exactly one cycle, then go to IDLE.
- Output register: c_write = out_valid & c_full_n and c_din = out_data. A load and a drain in the same cycle keep out_valid=1.
- Exactly n data tokens and then one eot token are written per invocation, in input order.

## Timing
- Reset values: state=IDLE, out_valid=0, remaining=0. Outputs: ap_idle=1; ap_done=ap_ready=0; a_s_read=b_s_read=c_write=0; c_din=0.
- Reset asserted mid-operation: return to IDLE on the next edge. The in-flight output token is discarded and no ap_done is issued.
- Start to first pop: 1 cycle (the IDLE→RUN edge). Pop to c_write: 1 cycle (registered).
- Throughput: 1 element/cycle when inputs are non-empty and C is never full.
- Minimum invocation with n==0: IDLE → CLOSE → DRAIN → DONE. ap_done is asserted 3 cycles after the start edge, assuming c_full_n=1.
- Only one input non-empty: no pop on either stream; never pop a single stream.
- ap_start high during DONE has no effect. It is re-evaluated only in IDLE, so back-to-back invocations have one IDLE cycle between them.
- The read strobes are combinational from the empty_n/full_n flags and the state. No combinational path from c_full_n to c_din.

## Structure
- Package add_stream_pkg:
  - state enum: IDLE=3'd0, RUN=1, CLOSE=2, DRAIN=3, DONE=4
  - EOT_BIT index function of DATA_WIDTH
  - EOT token constant
- Sub-module stream_out_reg: a one-entry output buffer.
  - Inputs: load and load_data.
  - Exposes valid, c_din, c_write and can_load = ~valid | c_full_n.
  - Reused by other custom-RTL tasks.
- Top: FSM, remaining counter, adder, fire logic.

## Test plan
- n=4, A={1,2,3,4}, B={10,20,30,40}, C never full → C receives 11,22,33,44 with eot=0 on consecutive cycles, then {eot=1, 0}; ap_done=ap_ready pulse once; ap_idle returns to 1.
- n=0 → C receives only the eot token; ap_done 3 cycles after the start edge.
- DATA_WIDTH=32, n=1, A=0xFFFFFFFF, B=2 → c_din={0, 0x00000001} (wrap).
- n=3 with random empty_n on A/B and random c_full_n deassertion → no pop unless both are non-empty; no word lost or duplicated; C order preserved; exactly 3 data tokens + 1 eot.
- Reset pulsed after 2 of 5 elements → outputs return to reset values on the next edge; a fresh start with n=2 produces exactly 2 data tokens + eot.
- ap_start held high across DONE → one ap_done per invocation; a second invocation begins only after one IDLE cycle.
